// File: rtl/ulpi_pkg.sv
// Shared constants, register map and state encoding for the ULPI PHY responder.
// ULPI_PHY_RXCMD_EN adds the RX CMD states to the responder state enum.
package ulpi_pkg;

   localparam logic [1:0]  TX_WRITE   = 2'b10;
   localparam logic [1:0]  TX_READ    = 2'b11;

   localparam logic [15:0] VENDOR_ID  = 16'h0424;
   localparam logic [15:0] PRODUCT_ID = 16'h0009;

   localparam logic [5:0]  ADDR_VID_LO = 6'h00;
   localparam logic [5:0]  ADDR_VID_HI = 6'h01;
   localparam logic [5:0]  ADDR_PID_LO = 6'h02;
   localparam logic [5:0]  ADDR_PID_HI = 6'h03;

   localparam int NUM_REGS  = 6;
   localparam int IDX_FUNC  = 0;
   localparam int IDX_OTG   = 2;

   // Base (write) address of each register; base+1 is set, base+2 is clear.
   // Order: scratch, ie_falling, ie_rising, otg_ctrl, iface_ctrl, func_ctrl.
   localparam logic [NUM_REGS-1:0][5:0] REG_BASE =
      {6'h16, 6'h10, 6'h0D, 6'h0A, 6'h07, 6'h04};
   localparam logic [NUM_REGS-1:0][7:0] REG_RESET =
      {8'h00, 8'h1F, 8'h1F, 8'h06, 8'h00, 8'h41};

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_SET   = 2'd1,
      OP_CLEAR = 2'd2
   } reg_op_e;

   typedef struct packed {
      logic    hit;
      logic [2:0] idx;
      reg_op_e op;
   } reg_dec_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_WDATA,
      S_WSTP,
      S_RTURN,
      S_RDATA,
      S_RTURN2
`ifdef ULPI_PHY_RXCMD_EN
      ,
      S_XTURN,
      S_XCMD,
      S_XTURN2
`endif
   } resp_state_e;

   function automatic reg_dec_t reg_decode(input logic [5:0] addr);
      reg_dec_t d;
      d.hit = 1'b0;
      d.idx = 3'd0;
      d.op  = OP_WRITE;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr >= REG_BASE[i] && addr <= REG_BASE[i] + 6'd2) begin
            d.hit = 1'b1;
            d.idx = 3'(i);
            d.op  = reg_op_e'(2'(addr - REG_BASE[i]));
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// PHY register file: alias decode (write/set/clear), Func Ctrl reset self-clear,
// read mux including the read-only vendor/product ID bytes.
module ulpi_phy_regfile
   import ulpi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [5:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [5:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [7:0] func_ctrl,
   output logic [7:0] otg_ctrl
);

   logic [NUM_REGS-1:0][7:0] regs_q;
   reg_dec_t   wdec;
   reg_dec_t   rdec;
   logic [7:0] wr_val;

   always_comb begin
      wdec   = reg_decode(wr_addr);
      wr_val = wr_data;
      case (wdec.op)
         OP_SET:   wr_val = regs_q[wdec.idx] | wr_data;
         OP_CLEAR: wr_val = regs_q[wdec.idx] & ~wr_data;
         default:  wr_val = wr_data;
      endcase
   end

   // Func Ctrl bit 5 is a pulse: cleared every cycle unless written this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= REG_RESET;
      end else begin
         regs_q[IDX_FUNC][5] <= 1'b0;
         if (wr_en && wdec.hit)
            regs_q[wdec.idx] <= wr_val;
      end
   end

   always_comb begin
      rdec = reg_decode(rd_addr);
      case (rd_addr)
         ADDR_VID_LO: rd_data = VENDOR_ID[7:0];
         ADDR_VID_HI: rd_data = VENDOR_ID[15:8];
         ADDR_PID_LO: rd_data = PRODUCT_ID[7:0];
         ADDR_PID_HI: rd_data = PRODUCT_ID[15:8];
         default:     rd_data = rdec.hit ? regs_q[rdec.idx] : 8'h00;
      endcase
   end

   assign func_ctrl = regs_q[IDX_FUNC];
   assign otg_ctrl  = regs_q[IDX_OTG];

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI responder: serves register TX CMDs from ulpi_phy_regfile and,
// with ULPI_PHY_RXCMD_EN defined, reports line/VBUS changes as RX CMD bytes.
//
// state    | meaning
// S_IDLE   | waiting for TX CMD or pending RX CMD
// S_CMD    | TX CMD accepted (nxt)
// S_WDATA  | write data byte accepted (nxt)
// S_WSTP   | stp commits the write, otherwise dropped
// S_RTURN  | read turnaround, PHY takes bus
// S_RDATA  | read data on data_out
// S_RTURN2 | bus handed back to link
// S_XTURN  | RX CMD turnaround, PHY takes bus
// S_XCMD   | RX CMD byte on data_out
// S_XTURN2 | bus handed back to link
module ulpi_phy_responder
   import ulpi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       stp,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       dir,
   output logic       nxt,
   input  logic [1:0] linestate,
   input  logic [1:0] vbus_state,
   output logic [7:0] func_ctrl,
   output logic [7:0] otg_ctrl
);

   resp_state_e state_q, state_d;
   logic       is_read_q, is_read_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       dir_d, nxt_d;
   logic [7:0] data_out_d;
   logic       wr_en;
   logic [7:0] rd_data;

   ulpi_phy_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (addr_q),
      .wr_data   (wdata_q),
      .rd_addr   (addr_q),
      .rd_data   (rd_data),
      .func_ctrl (func_ctrl),
      .otg_ctrl  (otg_ctrl)
   );

`ifdef ULPI_PHY_RXCMD_EN
   logic [7:0] rx_byte;
   logic [3:0] last_rep_q;
   logic       armed_q;
   logic       rx_pend;

   assign rx_byte = {4'b0000, vbus_state, linestate};
   // The first clock after reset only captures the baseline, so no RX CMD from reset.
   assign rx_pend = armed_q && (rx_byte[3:0] != last_rep_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q    <= 1'b0;
         last_rep_q <= 4'h0;
      end else begin
         armed_q <= 1'b1;
         if (!armed_q || state_q == S_XTURN)
            last_rep_q <= rx_byte[3:0];
      end
   end
`else
   logic unused_line_inputs;
   assign unused_line_inputs = ^{linestate, vbus_state};
`endif

   always_comb begin
      state_d   = state_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
`ifdef ULPI_PHY_RXCMD_EN
            if (rx_pend) begin
               state_d = S_XTURN;
            end else
`endif
            if (data_in[7:6] == TX_WRITE || data_in[7:6] == TX_READ) begin
               state_d   = S_CMD;
               is_read_d = (data_in[7:6] == TX_READ);
               addr_d    = data_in[5:0];
            end
         end
         S_CMD:    state_d = is_read_q ? S_RTURN : S_WDATA;
         S_WDATA: begin
            wdata_d = data_in;
            state_d = S_WSTP;
         end
         S_WSTP: begin
            wr_en   = stp;
            state_d = S_IDLE;
         end
         S_RTURN:  state_d = S_RDATA;
         S_RDATA:  state_d = S_RTURN2;
         S_RTURN2: state_d = S_IDLE;
`ifdef ULPI_PHY_RXCMD_EN
         S_XTURN:  state_d = S_XCMD;
         S_XCMD:   state_d = S_XTURN2;
         S_XTURN2: state_d = S_IDLE;
`endif
         default:  state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      nxt_d      = (state_d == S_CMD) || (state_d == S_WDATA);
      dir_d      = (state_d == S_RTURN) || (state_d == S_RDATA);
      data_out_d = (state_d == S_RDATA) ? rd_data : 8'h00;
`ifdef ULPI_PHY_RXCMD_EN
      if (state_d == S_XTURN || state_d == S_XCMD)
         dir_d = 1'b1;
      if (state_d == S_XCMD)
         data_out_d = rx_byte;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_read_q <= 1'b0;
         addr_q    <= 6'h00;
         wdata_q   <= 8'h00;
         dir       <= 1'b0;
         nxt       <= 1'b0;
         data_out  <= 8'h00;
      end else begin
         state_q   <= state_d;
         is_read_q <= is_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         dir       <= dir_d;
         nxt       <= nxt_d;
         data_out  <= data_out_d;
      end
   end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Bench for ulpi_phy_responder: table vectors, directed corner sequences and
// randomized register traffic against an address-arithmetic register model.
module tb_ulpi_phy_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       stp;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       dir;
   logic       nxt;
   logic [1:0] linestate;
   logic [1:0] vbus_state;
   logic [7:0] func_ctrl;
   logic [7:0] otg_ctrl;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] mreg [6];

   ulpi_phy_responder dut (
      .clk        (clk),
      .rst        (rst),
      .stp        (stp),
      .data_in    (data_in),
      .data_out   (data_out),
      .dir        (dir),
      .nxt        (nxt),
      .linestate  (linestate),
      .vbus_state (vbus_state),
      .func_ctrl  (func_ctrl),
      .otg_ctrl   (otg_ctrl)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Register model: index 0..5 = func, iface, otg, ie_rise, ie_fall, scratch.
   task automatic mreset();
      mreg[0] = 8'h41; mreg[1] = 8'h00; mreg[2] = 8'h06;
      mreg[3] = 8'h1F; mreg[4] = 8'h1F; mreg[5] = 8'h00;
   endtask

   function automatic logic [7:0] model_read(input int a);
      if (a == 0) return 8'h24;
      if (a == 1) return 8'h04;
      if (a == 2) return 8'h09;
      if (a == 3) return 8'h00;
      if (a >= 4 && a <= 18) return mreg[(a - 4) / 3];
      if (a >= 22 && a <= 24) return mreg[5];
      return 8'h00;
   endfunction

   task automatic model_write(input int a, input logic [7:0] d);
      int idx;
      int op;
      if (a >= 4 && a <= 18) begin
         idx = (a - 4) / 3;
         op  = (a - 4) % 3;
      end else if (a >= 22 && a <= 24) begin
         idx = 5;
         op  = a - 22;
      end else begin
         return;
      end
      if (op == 0)      mreg[idx] = d;
      else if (op == 1) mreg[idx] = mreg[idx] | d;
      else              mreg[idx] = mreg[idx] & ~d;
   endtask

   // Starts in an idle cycle N; returns in cycle N+4 (responder idle again).
   task automatic do_write(input int a, input logic [7:0] d, input bit with_stp);
      data_in = {2'b10, 6'(a)};
      tick();
      chk("wr_nxt_cmd", {7'b0, nxt}, 8'h01);
      chk("wr_dir_cmd", {7'b0, dir}, 8'h00);
      tick();
      chk("wr_nxt_data", {7'b0, nxt}, 8'h01);
      data_in = d;
      tick();
      chk("wr_nxt_stp", {7'b0, nxt}, 8'h00);
      data_in = 8'h00;
      stp = with_stp;
      tick();
      stp = 1'b0;
   endtask

   task automatic wr_chk(input int a, input logic [7:0] d, input bit with_stp);
      do_write(a, d, with_stp);
      if (with_stp) model_write(a, d);
      chk("wr_func_ctrl", func_ctrl, mreg[0]);
      chk("wr_otg_ctrl", otg_ctrl, mreg[2]);
      mreg[0][5] = 1'b0;
   endtask

   // Starts in an idle cycle N; returns in cycle N+5.
   task automatic do_read(input int a, output logic [7:0] q);
      data_in = {2'b11, 6'(a)};
      tick();
      chk("rd_nxt_cmd", {7'b0, nxt}, 8'h01);
      chk("rd_dir_cmd", {7'b0, dir}, 8'h00);
      data_in = 8'h00;
      tick();
      chk("rd_dir_turn", {7'b0, dir}, 8'h01);
      chk("rd_nxt_turn", {7'b0, nxt}, 8'h00);
      tick();
      chk("rd_dir_data", {7'b0, dir}, 8'h01);
      q = data_out;
      tick();
      chk("rd_dir_back", {7'b0, dir}, 8'h00);
      tick();
   endtask

   typedef struct {
      bit         is_rd;
      bit         with_stp;
      int         addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [23];

   initial begin
      logic [7:0] q;

      vecs[0]  = '{1'b0, 1'b1, 'h16, 8'hA5, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 'h16, 8'h00, 8'hA5};
      vecs[2]  = '{1'b0, 1'b1, 'h16, 8'hA0, 8'h00};
      vecs[3]  = '{1'b0, 1'b1, 'h17, 8'h0F, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 'h18, 8'h80, 8'h00};
      vecs[5]  = '{1'b1, 1'b0, 'h16, 8'h00, 8'h2F};
      vecs[6]  = '{1'b1, 1'b0, 'h00, 8'h00, 8'h24};
      vecs[7]  = '{1'b1, 1'b0, 'h01, 8'h00, 8'h04};
      vecs[8]  = '{1'b1, 1'b0, 'h02, 8'h00, 8'h09};
      vecs[9]  = '{1'b1, 1'b0, 'h03, 8'h00, 8'h00};
      vecs[10] = '{1'b1, 1'b0, 'h3F, 8'h00, 8'h00};
      vecs[11] = '{1'b0, 1'b1, 'h3F, 8'h55, 8'h00};
      vecs[12] = '{1'b1, 1'b0, 'h3F, 8'h00, 8'h00};
      vecs[13] = '{1'b0, 1'b0, 'h16, 8'h77, 8'h00};
      vecs[14] = '{1'b1, 1'b0, 'h17, 8'h00, 8'h2F};
      vecs[15] = '{1'b1, 1'b0, 'h07, 8'h00, 8'h00};
      vecs[16] = '{1'b1, 1'b0, 'h0B, 8'h00, 8'h06};
      vecs[17] = '{1'b0, 1'b1, 'h0C, 8'h02, 8'h00};
      vecs[18] = '{1'b1, 1'b0, 'h0A, 8'h00, 8'h04};
      vecs[19] = '{1'b1, 1'b0, 'h0E, 8'h00, 8'h1F};
      vecs[20] = '{1'b1, 1'b0, 'h12, 8'h00, 8'h1F};
      vecs[21] = '{1'b0, 1'b1, 'h13, 8'hFF, 8'h00};
      vecs[22] = '{1'b1, 1'b0, 'h13, 8'h00, 8'h00};

      rst        = 1'b1;
      stp        = 1'b0;
      data_in    = 8'h00;
      linestate  = 2'b10;
      vbus_state = 2'b00;
      mreset();
      tick();
      tick();
      chk("rst_dir", {7'b0, dir}, 8'h00);
      chk("rst_nxt", {7'b0, nxt}, 8'h00);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_func_ctrl", func_ctrl, 8'h41);
      chk("rst_otg_ctrl", otg_ctrl, 8'h06);
      rst = 1'b0;

      // Non-zero linestate at reset release must not produce an RX CMD.
      do_read('h0A, q);
      chk("post_rst_read", q, 8'h06);

      for (int i = 0; i < 23; i++) begin
         if (vecs[i].is_rd) begin
            do_read(vecs[i].addr, q);
            chk($sformatf("tbl_rd_%0d", i), q, vecs[i].exp);
         end else begin
            wr_chk(vecs[i].addr, vecs[i].data, vecs[i].with_stp);
         end
      end

      // Func Ctrl reset bit is a one-cycle pulse.
      do_write('h04, 8'h60, 1'b1);
      chk("func_pulse_hi", func_ctrl, 8'h60);
      tick();
      chk("func_pulse_lo", func_ctrl, 8'h40);
      mreg[0] = 8'h40;

`ifdef ULPI_PHY_RXCMD_EN
      // Line change with a TX CMD in the same cycle: RX CMD wins, link retries.
      linestate = 2'b01;
      data_in   = 8'h96;
      tick();
      chk("rx_nxt_turn", {7'b0, nxt}, 8'h00);
      chk("rx_dir_turn", {7'b0, dir}, 8'h01);
      tick();
      chk("rx_dir_cmd", {7'b0, dir}, 8'h01);
      chk("rx_nxt_cmd", {7'b0, nxt}, 8'h00);
      chk("rx_byte", data_out, 8'h01);
      tick();
      chk("rx_dir_back", {7'b0, dir}, 8'h00);
      chk("rx_nxt_back", {7'b0, nxt}, 8'h00);
      tick();
      chk("retry_nxt_idle", {7'b0, nxt}, 8'h00);
      chk("retry_dir_idle", {7'b0, dir}, 8'h00);
      tick();
      chk("retry_nxt_cmd", {7'b0, nxt}, 8'h01);
      tick();
      chk("retry_nxt_data", {7'b0, nxt}, 8'h01);
      data_in = 8'h3C;
      tick();
      chk("retry_nxt_stp", {7'b0, nxt}, 8'h00);
      data_in = 8'h00;
      stp = 1'b1;
      tick();
      stp = 1'b0;
      model_write('h16, 8'h3C);
`else
      linestate = 2'b01;
      wr_chk('h16, 8'h3C, 1'b1);
`endif
      do_read('h16, q);
      chk("retry_readback", q, 8'h3C);

      for (int i = 0; i < 200; i++) begin
         int         a;
         int         kind;
         logic [7:0] d;
         a    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 'h18) : $urandom_range(0, 'h3F);
         kind = $urandom_range(0, 2);
         d    = 8'($urandom);
         if (kind == 0) begin
            do_read(a, q);
            chk($sformatf("rnd_rd_%02h", a), q, model_read(a));
         end else begin
            wr_chk(a, d, kind == 1);
         end
      end

      // Reset during the read data cycle drops the bus at once.
      data_in = {2'b11, 6'h16};
      tick();
      data_in = 8'h00;
      tick();
      tick();
      chk("mid_rst_dir_before", {7'b0, dir}, 8'h01);
      rst = 1'b1;
      #1;
      chk("mid_rst_dir", {7'b0, dir}, 8'h00);
      chk("mid_rst_data_out", data_out, 8'h00);
      tick();
      rst = 1'b0;
      mreset();
      do_read('h16, q);
      chk("after_rst_scratch", q, 8'h00);
      do_read('h04, q);
      chk("after_rst_func", q, 8'h41);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
